hsclk_switch_ctrl_m: RTL and testbench

Parametrised successor to the fixed clock-select and IO-holdoff logic of the level-1b CPLD. It runs entirely on the high-speed clock and decides when the CPU clock multiplexer should switch between the BBC (low-speed) and high-speed clocks. It adds:
- a request/acknowledge state machine with synchronised acknowledges;
- a programmable IO-recovery holdoff counter, replacing the fixed-depth shift pipe;
- a saturating switch-event counter for firmware diagnostics.

---
 rtl/hsclk_switch_ctrl_m_if.sv | 34 +++
 rtl/hsclk_switch_ctrl_m.sv | 116 +++++++++++
 tb/tb_hsclk_switch_ctrl_m.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/hsclk_switch_ctrl_m_if.sv
// Bus-cycle qualifiers, clock-mux acknowledges and status outputs of the
// high-speed clock switch controller. master = bus/mux side, slave = controller.
interface hsclk_switch_ctrl_m_if #(
    parameter int HOLDOFF_W = 4,
    parameter int CNT_W     = 8
);
    logic                 cyc_valid;
    logic                 cyc_sync;
    logic                 cyc_idle;
    logic                 cyc_himem;
    logic                 cyc_io;
    logic                 cyc_slow_wr;
    logic                 hs_en;
    logic [HOLDOFF_W-1:0] holdoff_cfg;
    logic                 hs_ack_raw;
    logic                 ls_ack_raw;
    logic                 hsclk_sel;
    logic                 dummy_access;
    logic [1:0]           fsm_state;
    logic                 holdoff_busy;
    logic [CNT_W-1:0]     switch_cnt;

    modport master (
        output cyc_valid, cyc_sync, cyc_idle, cyc_himem, cyc_io, cyc_slow_wr,
               hs_en, holdoff_cfg, hs_ack_raw, ls_ack_raw,
        input  hsclk_sel, dummy_access, fsm_state, holdoff_busy, switch_cnt
    );

    modport slave (
        input  cyc_valid, cyc_sync, cyc_idle, cyc_himem, cyc_io, cyc_slow_wr,
               hs_en, holdoff_cfg, hs_ack_raw, ls_ack_raw,
        output hsclk_sel, dummy_access, fsm_state, holdoff_busy, switch_cnt
    );
endinterface

// File: rtl/hsclk_switch_ctrl_m.sv
// CPU clock-mux switch controller, running on hsclk.
// Request/ack FSM (LS, HS_REQ, HS, LS_REQ) with synchronised mux acks,
// programmable IO-recovery holdoff and a saturating LS->HS request counter.
// Optional macro CLKSEL_SLOW_WR_EN: when defined, slow himem writes
// (VRAM/LOMEM) block LS->HS and drop HS back to LS.
module hsclk_switch_ctrl_m #(
    parameter int HOLDOFF_W   = 4,
    parameter int SYNC_STAGES = 2,   // must be >= 2
    parameter int CNT_W       = 8
) (
    input  logic                  hsclk,
    input  logic                  reset,
    hsclk_switch_ctrl_m_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_LS     = 2'b00,
        ST_HS_REQ = 2'b01,
        ST_HS     = 2'b10,
        ST_LS_REQ = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic                 sel_q, sel_d;
    logic                 cnt_inc;
    logic [CNT_W-1:0]     cnt_q;
    logic [HOLDOFF_W-1:0] hold_q;
    logic [SYNC_STAGES-1:0] hs_sync_q, ls_sync_q;
    logic                 hs_ack, ls_ack;
    logic                 slow_wr_q;
    logic                 hold_busy;

`ifdef CLKSEL_SLOW_WR_EN
    assign slow_wr_q = bus.cyc_slow_wr;
`else
    assign slow_wr_q = 1'b0;
`endif

    // Acks come straight from the clock mux domain; plain flop chains.
    always_ff @(posedge hsclk or posedge reset) begin
        if (reset) begin
            hs_sync_q <= '0;
            ls_sync_q <= '0;
        end else begin
            hs_sync_q <= {hs_sync_q[SYNC_STAGES-2:0], bus.hs_ack_raw};
            ls_sync_q <= {ls_sync_q[SYNC_STAGES-2:0], bus.ls_ack_raw};
        end
    end

    assign hs_ack    = hs_sync_q[SYNC_STAGES-1];
    assign ls_ack    = ls_sync_q[SYNC_STAGES-1];
    assign hold_busy = (hold_q != '0);

    // Next state, next mux select and request-count strobe.
    always_comb begin
        state_d = state_q;
        cnt_inc = 1'b0;
        case (state_q)
            ST_LS: begin
                if (bus.cyc_valid && bus.hs_en && bus.cyc_sync && bus.cyc_himem &&
                    !hold_busy && !slow_wr_q) begin
                    state_d = ST_HS_REQ;
                    cnt_inc = 1'b1;
                end
            end
            ST_HS_REQ: begin
                // Losing the enable beats an ack landing in the same cycle.
                if (!bus.hs_en)   state_d = ST_LS_REQ;
                else if (hs_ack)  state_d = ST_HS;
            end
            ST_HS: begin
                if (!bus.hs_en)
                    state_d = ST_LS_REQ;
                else if (bus.cyc_valid &&
                         !((bus.cyc_himem && !slow_wr_q) || bus.cyc_idle))
                    state_d = ST_LS_REQ;
            end
            ST_LS_REQ: begin
                if (ls_ack) state_d = ST_LS;
            end
            default: state_d = ST_LS;
        endcase
        sel_d = (state_d == ST_HS_REQ) || (state_d == ST_HS);
    end

    // State, mux select and saturating switch counter.
    always_ff @(posedge hsclk or posedge reset) begin
        if (reset) begin
            state_q <= ST_LS;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            if (cnt_inc && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // IO holdoff: reload on an IO cycle, otherwise count bus cycles down to 0.
    always_ff @(posedge hsclk or posedge reset) begin
        if (reset)
            hold_q <= '0;
        else if (bus.cyc_valid && bus.cyc_io)
            hold_q <= bus.holdoff_cfg;
        else if (bus.cyc_valid && hold_busy)
            hold_q <= hold_q - 1'b1;
    end

    assign bus.hsclk_sel    = sel_q;
    assign bus.fsm_state    = state_q;
    assign bus.holdoff_busy = hold_busy;
    assign bus.switch_cnt   = cnt_q;
    assign bus.dummy_access = bus.cyc_himem || (state_q != ST_LS);

endmodule

// File: tb/tb_hsclk_switch_ctrl_m.sv
// Directed bench for hsclk_switch_ctrl_m (SYNC_STAGES=2, HOLDOFF_W=4, CNT_W=8).
module tb_hsclk_switch_ctrl_m;

    logic hsclk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    hsclk_switch_ctrl_m_if #(.HOLDOFF_W(4), .CNT_W(8)) bus ();

    hsclk_switch_ctrl_m #(.HOLDOFF_W(4), .SYNC_STAGES(2), .CNT_W(8)) dut (
        .hsclk (hsclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 hsclk = ~hsclk;

    task automatic tick();
        @(posedge hsclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cyc_valid strobe with the given qualifiers, then back to idle bus.
    task automatic strobe(input logic s, input logic idl, input logic hm,
                          input logic io, input logic sw);
        bus.cyc_valid   = 1'b1;
        bus.cyc_sync    = s;
        bus.cyc_idle    = idl;
        bus.cyc_himem   = hm;
        bus.cyc_io      = io;
        bus.cyc_slow_wr = sw;
        tick();
        bus.cyc_valid   = 1'b0;
        bus.cyc_sync    = 1'b0;
        bus.cyc_idle    = 1'b0;
        bus.cyc_himem   = 1'b0;
        bus.cyc_io      = 1'b0;
        bus.cyc_slow_wr = 1'b0;
    endtask

    // Hand the LS_REQ state an ls ack and let it settle back in LS.
    task automatic ls_handshake();
        bus.ls_ack_raw = 1'b1;
        tick(); tick(); tick();
        chk("ls_ack_to_LS", bus.fsm_state, 2'b00);
        bus.ls_ack_raw = 1'b0;
        tick(); tick();
    endtask

    initial begin
        bus.cyc_valid = 0; bus.cyc_sync = 0; bus.cyc_idle = 0; bus.cyc_himem = 0;
        bus.cyc_io = 0; bus.cyc_slow_wr = 0; bus.hs_en = 0; bus.holdoff_cfg = '0;
        bus.hs_ack_raw = 0; bus.ls_ack_raw = 0;

        // Reset state
        #1;
        chk("rst_sel",   bus.hsclk_sel, 0);
        chk("rst_state", bus.fsm_state, 2'b00);
        chk("rst_busy",  bus.holdoff_busy, 0);
        chk("rst_cnt",   bus.switch_cnt, 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("ls_dummy_off", bus.dummy_access, 0);
        bus.cyc_himem = 1'b1; #1;
        chk("ls_dummy_himem", bus.dummy_access, 1);
        bus.cyc_himem = 1'b0;

        // LS -> HS_REQ, one-cycle latency on hsclk_sel
        bus.hs_en = 1'b1;
        strobe(1, 0, 1, 0, 0); exp_cnt++;
        chk("req_sel",   bus.hsclk_sel, 1);
        chk("req_state", bus.fsm_state, 2'b01);
        chk("req_cnt",   bus.switch_cnt, exp_cnt);
        chk("req_dummy", bus.dummy_access, 1);

        // hs ack needs SYNC_STAGES+1 cycles to land in HS
        bus.hs_ack_raw = 1'b1;
        tick(); tick();
        chk("ack_2cyc_state", bus.fsm_state, 2'b01);
        tick();
        chk("ack_3cyc_state", bus.fsm_state, 2'b10);

        // HS holds on idle and himem cycles
        strobe(0, 1, 0, 0, 0);
        chk("hs_idle_stay", bus.fsm_state, 2'b10);
        strobe(0, 0, 1, 0, 0);
        chk("hs_himem_stay", bus.fsm_state, 2'b10);

        // IO cycle in HS with holdoff 5
        bus.holdoff_cfg = 4'd5;
        strobe(0, 0, 0, 1, 0);
        chk("io_state", bus.fsm_state, 2'b11);
        chk("io_sel",   bus.hsclk_sel, 0);
        chk("io_busy",  bus.holdoff_busy, 1);
        bus.hs_ack_raw = 1'b0;
        ls_handshake();
        chk("hold_busy_no_cyc", bus.holdoff_busy, 1);
        for (int i = 0; i < 5; i++) begin
            strobe(1, 0, 1, 0, 0);
            chk("hold_blocked_state", bus.fsm_state, 2'b00);
            chk("hold_blocked_sel",   bus.hsclk_sel, 0);
        end
        chk("hold_expired", bus.holdoff_busy, 0);
        strobe(1, 0, 1, 0, 0); exp_cnt++;
        chk("hold_6th_sel", bus.hsclk_sel, 1);
        chk("hold_6th_cnt", bus.switch_cnt, exp_cnt);

        // hs_en drop in the very cycle the ack becomes visible
        bus.hs_ack_raw = 1'b1;
        tick(); tick();
        bus.hs_en = 1'b0;
        tick();
        chk("en_vs_ack_state", bus.fsm_state, 2'b11);
        chk("en_vs_ack_sel",   bus.hsclk_sel, 0);
        bus.hs_ack_raw = 1'b0;
        bus.hs_en = 1'b1;
        tick();
        chk("lsreq_ignore_en", bus.fsm_state, 2'b11);
        chk("lsreq_ignore_en_sel", bus.hsclk_sel, 0);
        ls_handshake();

        // Raw acks in the wrong state
        bus.hs_ack_raw = 1'b1;
        bus.ls_ack_raw = 1'b1;
        tick(); tick(); tick(); tick();
        chk("stray_ack_state", bus.fsm_state, 2'b00);
        chk("stray_ack_sel",   bus.hsclk_sel, 0);
        bus.hs_ack_raw = 1'b0;
        bus.ls_ack_raw = 1'b0;
        tick(); tick();

        // Back to HS, then slow himem write
        strobe(1, 0, 1, 0, 0); exp_cnt++;
        bus.hs_ack_raw = 1'b1;
        tick(); tick(); tick();
        chk("hs2_state", bus.fsm_state, 2'b10);
        strobe(0, 0, 1, 0, 1);
`ifdef CLKSEL_SLOW_WR_EN
        chk("slow_wr_hs", bus.fsm_state, 2'b11);
`else
        chk("slow_wr_hs", bus.fsm_state, 2'b10);
`endif
        // hs_en low drops HS without any bus cycle
        bus.hs_en = 1'b0;
        tick();
        chk("hs_en_drop_state", bus.fsm_state, 2'b11);
        chk("hs_en_drop_sel",   bus.hsclk_sel, 0);
        bus.hs_ack_raw = 1'b0;
        ls_handshake();

        // Slow write blocking LS->HS
        bus.hs_en = 1'b1;
        strobe(1, 0, 1, 0, 1);
`ifdef CLKSEL_SLOW_WR_EN
        chk("slow_wr_ls", bus.fsm_state, 2'b00);
        strobe(1, 0, 1, 0, 0);
`endif
        exp_cnt++;
        chk("req3_state", bus.fsm_state, 2'b01);
        chk("req3_cnt",   bus.switch_cnt, exp_cnt);

        // Holdoff loaded while in HS_REQ, then asynchronous reset
        bus.holdoff_cfg = 4'd3;
        strobe(0, 0, 0, 1, 0);
        chk("hsreq_io_state", bus.fsm_state, 2'b01);
        chk("hsreq_io_busy",  bus.holdoff_busy, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_sel",   bus.hsclk_sel, 0);
        chk("arst_state", bus.fsm_state, 2'b00);
        chk("arst_busy",  bus.holdoff_busy, 0);
        chk("arst_cnt",   bus.switch_cnt, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_state", bus.fsm_state, 2'b00);

        // 300 round trips saturate the switch counter
        bus.holdoff_cfg = 4'd0;
        bus.ls_ack_raw  = 1'b1;
        tick(); tick();
        for (int i = 0; i < 300; i++) begin
            bus.hs_en = 1'b1;
            strobe(1, 0, 1, 0, 0);
            if (i == 254) chk("cnt_255th", bus.switch_cnt, 255);
            bus.hs_en = 1'b0;
            tick(); tick();
        end
        chk("cnt_sat", bus.switch_cnt, 255);
        chk("loop_end_state", bus.fsm_state, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
